dual_branch_predictor: RTL
==========================

Name: dual_branch_predictor

Overview:
- Fetch-side branch predictor for the dual-issue pipeline; the producing end of the prediction path whose results are checked and corrected in Execute.
- Combines a direct-mapped table of 2-bit saturating counters (BHT) with a direct-mapped tagged BTB.
- Two lookup ports serve the fetch pair (combinational read); two update ports are written from the resolved Execute pair.
- Also keeps a saturating misprediction counter for performance statistics.

Parameters:
- PC_W, 8, width of word-addressed PC and branch targets.
- IDX_BITS, 4, index bits; the table has 2^IDX_BITS entries, indexed by PC[IDX_BITS-1:0].
- CNT_W, 16, width of the misprediction statistics counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- PCF1  in  PC_W  fetch PC, slot 1 (older).
- PCF2  in  PC_W  fetch PC, slot 2 (younger).
- PredictionF1  out  1  predict-taken, slot 1.
- PredictionF2  out  1  predict-taken, slot 2.
- PredictedPCF1  out  PC_W  next-PC guess, slot 1.
- PredictedPCF2  out  PC_W  next-PC guess, slot 2.
- BranchE1  in  1  slot 1 in Execute is a resolved conditional branch.
- BranchE2  in  1  slot 2 in Execute is a resolved conditional branch.
- branch_taken1  in  1  actual outcome, slot 1.
- branch_taken2  in  1  actual outcome, slot 2.
- PredictionE1  in  1  prediction carried down the pipe with slot 1.
- PredictionE2  in  1  prediction carried down the pipe with slot 2.
- PCE1  in  PC_W  PC of the Execute slot 1 instruction.
- PCE2  in  PC_W  PC of the Execute slot 2 instruction.
- branchAdderResultE1  in  PC_W  resolved target, slot 1.
- branchAdderResultE2  in  PC_W  resolved target, slot 2.
- MispredictCount  out  CNT_W  saturating count of mispredicted branches.

Behaviour:
- Reset, asynchronous while reset=0:
  - every counter = 2'b01 (weakly not-taken);
  - every BTB valid = 0, tags and targets = 0;
  - MispredictCount = 0.
- Outputs during reset follow the lookup rules below against the reset state: PredictionF* = 0, PredictedPCF* = PCF*+1.
- Lookup, combinational with zero latency, evaluated independently per slot:
  - idx = PC[IDX_BITS-1:0]; tag = PC[PC_W-1:IDX_BITS].
  - hit = valid[idx] & (tag_mem[idx] == tag).
  - Prediction = hit & counter[idx][1].
  - PredictedPC = target[idx] if Prediction = 1, else PC+1, modulo 2^PC_W (0xFF+1 wraps to 0x00).
- Read-during-write: a lookup always returns pre-edge state. An update becomes visible to lookups on the cycle after its clock edge; there is no bypass.
- Update valid conditions:
  - upd1 = BranchE1.
  - mis1 = BranchE1 & (branch_taken1 != PredictionE1).
  - upd2 = BranchE2 & ~mis1. Slot 2 is wrong-path when slot 1 mispredicts, so its update is squashed.
  - mis2 = upd2 & (branch_taken2 != PredictionE2).
- Counter update: taken -> min(c+1, 3); not taken -> max(c-1, 0).
- BTB update: taken writes valid = 1, tag = PCE[PC_W-1:IDX_BITS], target = branchAdderResultE. Not taken leaves the BTB entry unchanged.
- Both slots updating the same idx in one cycle:
  - counter result = sat(sat(c, taken1), taken2), i.e. slot 1 applied first, then slot 2;
  - BTB: slot 2's write wins if it is taken; otherwise slot 1's write stands.
- Aliasing: different PCs with the same idx share a counter. The tag check applies only to the BTB, so a tag miss forces predict-not-taken.
- MispredictCount: add mis1 + mis2 (0, 1 or 2) per cycle; saturate at 2^CNT_W-1 and never wrap.
- All updates are single-cycle with no handshake and no stall input; Execute holds a slot's inputs for exactly one cycle per branch.
- Reset asserted mid-operation clears all state immediately; an update sampled in the same cycle is lost.

Decomposition:
- Shared package (pipeline-wide):
  - PC_W;
  - counter encodings SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11;
  - reset counter value WNT;
  - the saturating-update function.
- Sub-module bht_entry_update: pure combinational next-state logic for one counter given up to two ordered outcomes. Instantiated once per index slot, or shared by the two write ports.
- The top level holds the arrays, the lookup muxes and the statistics counter.

Test Plan:
- Reset, then PCF1=0x10, PCF2=0x11 -> PredictionF1/F2 = 0, PredictedPCF1 = 0x11, PredictedPCF2 = 0x12, MispredictCount = 0.
- Train taken: BranchE1=1, PCE1=0x10, branch_taken1=1, target 0x40, PredictionE1=0 for one cycle -> next cycle PCF1=0x10 gives PredictionF1 = 1, PredictedPCF1 = 0x40, MispredictCount = 1.
- Saturation: four taken updates at 0x10, then one not-taken -> counter goes 3 then 2, prediction still 1; a second not-taken -> counter 1, prediction 0.
- Squash: slot 1 mispredicts while BranchE2=1 for PCE2=0x25 taken -> entry 0x5 unchanged (lookup 0x25 predicts 0, PredictedPC = 0x26), count increments by 1 only.
- Same-index dual update: PCE1=0x03 not-taken, PCE2=0x13 taken, counter starting at 1, both predictions correct -> counter ends at 1; BTB tag = 1 and target = slot 2's; lookup 0x03 is a tag miss and predicts 0.
- Wrap and saturation: PCF1=0xFF, no hit -> PredictedPCF1 = 0x00. Force MispredictCount to 0xFFFF via CNT_W override, then a double mispredict -> value stays 0xFFFF.

Source files
------------

// File: rtl/dual_branch_predictor_pkg.sv
// dual_branch_predictor_pkg: shared widths, counter encodings and saturating update
package dual_branch_predictor_pkg;
  localparam int PC_W = 8;
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} bht_cnt_e;
  localparam logic [1:0] CNT_RST = WNT;
  function automatic logic [1:0] sat_update(input logic [1:0] c, input logic taken);
    return taken ? ((c == ST) ? c : c + 2'd1) : ((c == SNT) ? c : c - 2'd1);
  endfunction
endpackage

// File: rtl/dual_branch_predictor_bht_entry_update.sv
// bht_entry_update: next value of one 2-bit counter after up to two ordered outcomes
module bht_entry_update (
  input  logic [1:0] cnt_in,
  input  logic       en1,
  input  logic       taken1,
  input  logic       en2,
  input  logic       taken2,
  output logic [1:0] cnt_out
);
  import dual_branch_predictor_pkg::*;
  logic [1:0] mid;
  // Slot 1 is applied first, then slot 2 sees slot 1's result
  always_comb begin
    mid = en1 ? sat_update(cnt_in, taken1) : cnt_in;
    cnt_out = en2 ? sat_update(mid, taken2) : mid;
  end
endmodule

// File: rtl/dual_branch_predictor.sv
// dual_branch_predictor: dual-port BHT + tagged BTB with misprediction statistics
module dual_branch_predictor #(
  parameter int PC_W     = dual_branch_predictor_pkg::PC_W,
  parameter int IDX_BITS = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PC_W-1:0]  PCF1,
  input  logic [PC_W-1:0]  PCF2,
  output logic             PredictionF1,
  output logic             PredictionF2,
  output logic [PC_W-1:0]  PredictedPCF1,
  output logic [PC_W-1:0]  PredictedPCF2,
  input  logic             BranchE1,
  input  logic             BranchE2,
  input  logic             branch_taken1,
  input  logic             branch_taken2,
  input  logic             PredictionE1,
  input  logic             PredictionE2,
  input  logic [PC_W-1:0]  PCE1,
  input  logic [PC_W-1:0]  PCE2,
  input  logic [PC_W-1:0]  branchAdderResultE1,
  input  logic [PC_W-1:0]  branchAdderResultE2,
  output logic [CNT_W-1:0] MispredictCount
);
  import dual_branch_predictor_pkg::*;
  localparam int N = 1 << IDX_BITS;
  localparam int TAG_W = PC_W - IDX_BITS;
  logic [N-1:0][1:0]       cnt_q, cnt_d;
  logic [N-1:0]            valid_q, valid_d;
  logic [N-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [N-1:0][PC_W-1:0]  tgt_q, tgt_d;
  logic [CNT_W-1:0]        mcnt_q, mcnt_d;
  logic [CNT_W:0]          mcnt_sum;
  logic [IDX_BITS-1:0]     idx_e1, idx_e2, idx_f1, idx_f2;
  logic                    upd1, upd2, mis1, mis2;
  assign idx_e1 = PCE1[IDX_BITS-1:0];
  assign idx_e2 = PCE2[IDX_BITS-1:0];
  assign idx_f1 = PCF1[IDX_BITS-1:0];
  assign idx_f2 = PCF2[IDX_BITS-1:0];
  // A slot-1 mispredict makes slot 2 wrong-path, so its update is squashed
  assign upd1 = BranchE1;
  assign mis1 = upd1 && (branch_taken1 != PredictionE1);
  assign upd2 = BranchE2 && !mis1;
  assign mis2 = upd2 && (branch_taken2 != PredictionE2);
  for (genvar i = 0; i < N; i++) begin : g_bht
    bht_entry_update u_upd (
      .cnt_in  (cnt_q[i]),
      .en1     (upd1 && idx_e1 == IDX_BITS'(i)),
      .taken1  (branch_taken1),
      .en2     (upd2 && idx_e2 == IDX_BITS'(i)),
      .taken2  (branch_taken2),
      .cnt_out (cnt_d[i])
    );
  end
  // BTB writes on taken only; slot 2 is written last so it wins on a shared index
  always_comb begin
    valid_d = valid_q;
    tag_d = tag_q;
    tgt_d = tgt_q;
    if (upd1 && branch_taken1) begin
      valid_d[idx_e1] = 1'b1;
      tag_d[idx_e1] = PCE1[PC_W-1:IDX_BITS];
      tgt_d[idx_e1] = branchAdderResultE1;
    end
    if (upd2 && branch_taken2) begin
      valid_d[idx_e2] = 1'b1;
      tag_d[idx_e2] = PCE2[PC_W-1:IDX_BITS];
      tgt_d[idx_e2] = branchAdderResultE2;
    end
  end
  // Misprediction statistics saturate at all-ones instead of wrapping
  always_comb begin
    mcnt_sum = {1'b0, mcnt_q} + (CNT_W+1)'(mis1) + (CNT_W+1)'(mis2);
    mcnt_d = mcnt_sum[CNT_W] ? '1 : mcnt_sum[CNT_W-1:0];
  end
  // Lookups read pre-edge state only; a tag miss forces not-taken
  always_comb begin
    PredictionF1 = valid_q[idx_f1] && (tag_q[idx_f1] == PCF1[PC_W-1:IDX_BITS]) && cnt_q[idx_f1][1];
    PredictionF2 = valid_q[idx_f2] && (tag_q[idx_f2] == PCF2[PC_W-1:IDX_BITS]) && cnt_q[idx_f2][1];
    PredictedPCF1 = PredictionF1 ? tgt_q[idx_f1] : PCF1 + PC_W'(1);
    PredictedPCF2 = PredictionF2 ? tgt_q[idx_f2] : PCF2 + PC_W'(1);
  end
  assign MispredictCount = mcnt_q;
  // State registers, cleared asynchronously while reset is low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= {N{CNT_RST}};
      valid_q <= '0;
      tag_q <= '0;
      tgt_q <= '0;
      mcnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      valid_q <= valid_d;
      tag_q <= tag_d;
      tgt_q <= tgt_d;
      mcnt_q <= mcnt_d;
    end
  end
endmodule
